// File: rtl/burst_line_ctrl.sv
// rtl/burst_line_ctrl.sv - line-granular request front end for a burst RAM
//
// Purpose: accepts one line request at a time from a client and turns it
// into a single burst command on the RAM side. Reads collect BURST_COUNT
// beats (gaps allowed) into a line; writes stream BURST_COUNT beats back
// to back starting in the command cycle.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_ready      client request handshake
//   req_write, req_addr      line write flag and line address
//   req_wr_line              write line, beat k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   resp_valid, resp_rd_line one-cycle completion pulse and read line
//   ram_cmd, ram_cmd_en      burst command (1 = write) and its one-cycle strobe
//   ram_addr                 RAM word address, line aligned
//   ram_wr_data              write beat stream
//   ram_data_mask            byte mask, always 0
//   ram_rd_data(_valid)      returned read beats
//   ram_busy                 RAM cannot take a new command
//
// Configuration: define BURST_LINE_CTRL_WRITE_EN for line writes. Without
// it every request is a read and ram_cmd / ram_wr_data are tied to 0.
module burst_line_ctrl #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT    = 4,
  parameter int DATA_BITWIDTH  = 64
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               req_valid,
  input  logic                                               req_write,
  input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]      req_addr,
  input  logic [BURST_COUNT*DATA_BITWIDTH-1:0]               req_wr_line,
  output logic                                               req_ready,
  output logic                                               resp_valid,
  output logic [BURST_COUNT*DATA_BITWIDTH-1:0]               resp_rd_line,
  output logic                                               ram_cmd,
  output logic                                               ram_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]                          ram_addr,
  output logic [DATA_BITWIDTH-1:0]                           ram_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                         ram_data_mask,
  input  logic [DATA_BITWIDTH-1:0]                           ram_rd_data,
  input  logic                                               ram_rd_data_valid,
  input  logic                                               ram_busy
);

  localparam int BEAT_BITS = $clog2(BURST_COUNT);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
`ifdef BURST_LINE_CTRL_WRITE_EN
    WR_BURST,
`endif
    RD_COLLECT,
    RESP
  } state_t;

  state_t                                   state_q;
  logic [BEAT_BITS-1:0]                     beat_cnt_q;
  logic [BEAT_BITS-1:0]                     beat_nxt;
  logic                                     resp_valid_q;
  logic                                     cmd_en_q;
  logic [DEPTH_BITWIDTH-1:0]                addr_q;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] line_q;
  logic                                     accept;

  // Natural wrap of the counter puts it back at 0 when the last beat retires.
  assign beat_nxt = beat_cnt_q + BEAT_BITS'(1);

  assign req_ready = (state_q == IDLE) && !ram_busy && !rst;
  assign accept    = req_valid && req_ready;

`ifdef BURST_LINE_CTRL_WRITE_EN
  logic                                     write_q;
  logic                                     ram_cmd_q;
  logic [DATA_BITWIDTH-1:0]                 wr_data_q;
  logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] wr_beats_q;

  assign ram_cmd     = ram_cmd_q;
  assign ram_wr_data = wr_data_q;
`else
  logic unused_wr_inputs;

  assign unused_wr_inputs = ^{req_write, req_wr_line};
  assign ram_cmd          = 1'b0;
  assign ram_wr_data      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      cmd_en_q     <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
`ifdef BURST_LINE_CTRL_WRITE_EN
      write_q      <= 1'b0;
      ram_cmd_q    <= 1'b0;
      wr_data_q    <= '0;
      wr_beats_q   <= '0;
`endif
    end else begin
      // Both strobes are single-cycle; only the entering transition raises them.
      cmd_en_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= CMD;
            cmd_en_q   <= 1'b1;
            addr_q     <= {req_addr, BEAT_BITS'(0)};
            beat_cnt_q <= '0;
`ifdef BURST_LINE_CTRL_WRITE_EN
            write_q    <= req_write;
            ram_cmd_q  <= req_write;
            wr_beats_q <= req_wr_line;
            // Beat 0 rides along with the command strobe.
            wr_data_q  <= req_wr_line[DATA_BITWIDTH-1:0];
`endif
          end
        end
        CMD: begin
          state_q    <= RD_COLLECT;
          beat_cnt_q <= '0;
`ifdef BURST_LINE_CTRL_WRITE_EN
          if (write_q) begin
            state_q    <= WR_BURST;
            beat_cnt_q <= beat_nxt;
            wr_data_q  <= wr_beats_q[beat_nxt];
          end
`endif
        end
`ifdef BURST_LINE_CTRL_WRITE_EN
        WR_BURST: begin
          // The RAM takes the whole burst unthrottled once the command is issued.
          beat_cnt_q <= beat_nxt;
          if (beat_cnt_q == LAST_BEAT) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            wr_data_q <= wr_beats_q[beat_nxt];
          end
        end
`endif
        RD_COLLECT: begin
          if (ram_rd_data_valid) begin
            line_q[beat_cnt_q] <= ram_rd_data;
            beat_cnt_q         <= beat_nxt;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rd_line  = line_q;
  assign ram_cmd_en    = cmd_en_q;
  assign ram_addr      = addr_q;
  assign ram_data_mask = '0;

endmodule

// File: tb/tb_burst_line_ctrl.sv
// tb/tb_burst_line_ctrl.sv - self-checking bench for burst_line_ctrl
module tb_burst_line_ctrl;

  localparam int DW = 64;
  localparam int BC = 4;
  localparam int LW = BC * DW;

  typedef logic [255:0] w_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_write;
  logic [1:0]    req_addr;
  logic [LW-1:0] req_wr_line;
  logic          req_ready;
  logic          resp_valid;
  logic [LW-1:0] resp_rd_line;
  logic          ram_cmd;
  logic          ram_cmd_en;
  logic [3:0]    ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [7:0]    ram_data_mask;
  logic [DW-1:0] ram_rd_data;
  logic          ram_rd_data_valid;
  logic          ram_busy;

  int checks;
  int failures;
  int cmd_cnt;
  int resp_cnt;
  logic [DW-1:0] mem [16];
  logic [LW-1:0] last_line;

  burst_line_ctrl dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wr_line(req_wr_line),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_rd_line(resp_rd_line),
    .ram_cmd(ram_cmd),
    .ram_cmd_en(ram_cmd_en),
    .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data),
    .ram_data_mask(ram_data_mask),
    .ram_rd_data(ram_rd_data),
    .ram_rd_data_valid(ram_rd_data_valid),
    .ram_busy(ram_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ram_cmd_en === 1'b1) cmd_cnt++;
    if (resp_valid === 1'b1) resp_cnt++;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] model_line(input int line);
    logic [LW-1:0] l;
    for (int k = 0; k < BC; k++) l[k*DW +: DW] = mem[line*BC + k];
    return l;
  endfunction

  // Holds req_valid until accepted; ram_busy is held high for busy_cycles first.
  task automatic accept_req(input int busy_cycles, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      ram_busy = (i < busy_cycles);
      #1;
      if (ram_busy) begin
        chk("busy_ready_low", w_t'(req_ready), w_t'(0));
        chk("busy_no_cmd", w_t'(ram_cmd_en), w_t'(0));
      end
      if (req_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    ram_busy  = 1'b0;
    if (!ok) chk("accept_timeout", w_t'(0), w_t'(1));
  endtask

  task automatic do_read(input int line, input int maxgap, input int gap2,
                         input bit wr_flag, input int busy_cycles);
    logic [LW-1:0] exp_line;
    bit ok;
    int c0;
    int r0;
    exp_line    = model_line(line);
    c0          = cmd_cnt;
    r0          = resp_cnt;
    req_addr    = 2'(line);
    req_write   = wr_flag;
    req_wr_line = rand_line();
    accept_req(busy_cycles, ok);
    if (!ok) return;
    req_write = 1'b0;
    chk("rd_cmd_en", w_t'(ram_cmd_en), w_t'(1));
    chk("rd_addr", w_t'(ram_addr), w_t'(line * BC));
    chk("rd_cmd", w_t'(ram_cmd), w_t'(0));
    chk("rd_mask", w_t'(ram_data_mask), w_t'(0));
`ifndef BURST_LINE_CTRL_WRITE_EN
    chk("ro_wr_data", w_t'(ram_wr_data), w_t'(0));
`endif
    tick();
    for (int k = 0; k < BC; k++) begin
      int gap;
      gap = $urandom_range(0, maxgap) + ((k == 2) ? gap2 : 0);
      for (int g = 0; g < gap; g++) begin
        ram_rd_data_valid = 1'b0;
        ram_rd_data       = {$urandom, $urandom};
        tick();
      end
      ram_rd_data_valid = 1'b1;
      ram_rd_data       = mem[line*BC + k];
      tick();
    end
    ram_rd_data_valid = 1'b0;
    chk("rd_resp_valid", w_t'(resp_valid), w_t'(1));
    chk("rd_line", w_t'(resp_rd_line), w_t'(exp_line));
    chk("rd_cmd_pulses", w_t'(cmd_cnt - c0), w_t'(1));
    chk("rd_resp_pulses", w_t'(resp_cnt - r0), w_t'(1));
    last_line = exp_line;
    tick();
    chk("rd_resp_clear", w_t'(resp_valid), w_t'(0));
  endtask

`ifdef BURST_LINE_CTRL_WRITE_EN
  task automatic do_write(input int line, input logic [LW-1:0] wl);
    bit ok;
    int c0;
    int r0;
    c0          = cmd_cnt;
    r0          = resp_cnt;
    req_addr    = 2'(line);
    req_write   = 1'b1;
    req_wr_line = wl;
    accept_req(0, ok);
    if (!ok) return;
    req_write = 1'b0;
    chk("wr_cmd_en", w_t'(ram_cmd_en), w_t'(1));
    chk("wr_cmd", w_t'(ram_cmd), w_t'(1));
    chk("wr_addr", w_t'(ram_addr), w_t'(line * BC));
    chk("wr_beat0", w_t'(ram_wr_data), w_t'(wl[DW-1:0]));
    for (int k = 1; k < BC; k++) begin
      tick();
      chk("wr_beat", w_t'(ram_wr_data), w_t'(wl[k*DW +: DW]));
      chk("wr_cmd_en_low", w_t'(ram_cmd_en), w_t'(0));
      chk("wr_resp_early", w_t'(resp_valid), w_t'(0));
    end
    tick();
    chk("wr_resp_valid", w_t'(resp_valid), w_t'(1));
    chk("wr_line_kept", w_t'(resp_rd_line), w_t'(last_line));
    chk("wr_cmd_pulses", w_t'(cmd_cnt - c0), w_t'(1));
    chk("wr_resp_pulses", w_t'(resp_cnt - r0), w_t'(1));
    for (int k = 0; k < BC; k++) mem[line*BC + k] = wl[k*DW +: DW];
    tick();
    chk("wr_resp_clear", w_t'(resp_valid), w_t'(0));
  endtask
`endif

  initial begin
    bit ok;
    int r0;
    logic [LW-1:0] wl;
    checks            = 0;
    failures          = 0;
    cmd_cnt           = 0;
    resp_cnt          = 0;
    last_line         = '0;
    rst               = 1'b1;
    req_valid         = 1'b0;
    req_write         = 1'b0;
    req_addr          = '0;
    req_wr_line       = '0;
    ram_rd_data       = '0;
    ram_rd_data_valid = 1'b0;
    ram_busy          = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};

    // Reset state.
    repeat (3) tick();
    chk("rst_ready", w_t'(req_ready), w_t'(0));
    chk("rst_resp_valid", w_t'(resp_valid), w_t'(0));
    chk("rst_line", w_t'(resp_rd_line), w_t'(0));
    chk("rst_cmd_en", w_t'(ram_cmd_en), w_t'(0));
    chk("rst_addr", w_t'(ram_addr), w_t'(0));
    chk("rst_cmd", w_t'(ram_cmd), w_t'(0));
    chk("rst_wr_data", w_t'(ram_wr_data), w_t'(0));
    rst = 1'b0;
    tick();
    chk("idle_ready", w_t'(req_ready), w_t'(1));

    // Read line 1 with known contents.
    mem[4] = 64'h1111_1111_1111_1111;
    mem[5] = 64'h2222_2222_2222_2222;
    mem[6] = 64'h3333_3333_3333_3333;
    mem[7] = 64'h4444_4444_4444_4444;
    do_read(1, 0, 0, 1'b0, 0);

`ifdef BURST_LINE_CTRL_WRITE_EN
    // Write line 2 with beats A0..A3, then read it back.
    for (int k = 0; k < BC; k++) wl[k*DW +: DW] = DW'(8'hA0 + k);
    do_write(2, wl);
    do_read(2, 1, 0, 1'b0, 0);
`endif

    // Request held while RAM is busy.
    do_read(3, 0, 0, 1'b0, 5);

    // Stray valid beats in IDLE, then a read with a 2-cycle gap before beat 2.
    ram_rd_data_valid = 1'b1;
    ram_rd_data       = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    tick();
    chk("stray_no_resp", w_t'(resp_valid), w_t'(0));
    ram_rd_data_valid = 1'b0;
    do_read(0, 0, 2, 1'b0, 0);

    // Reset after two beats of a read aborts it silently.
    req_addr = 2'd2;
    accept_req(0, ok);
    tick();
    for (int k = 0; k < 2; k++) begin
      ram_rd_data_valid = 1'b1;
      ram_rd_data       = mem[8 + k];
      tick();
    end
    ram_rd_data_valid = 1'b0;
    r0  = resp_cnt;
    rst = 1'b1;
    tick();
    chk("abort_ready", w_t'(req_ready), w_t'(0));
    chk("abort_resp_valid", w_t'(resp_valid), w_t'(0));
    chk("abort_line", w_t'(resp_rd_line), w_t'(0));
    chk("abort_cmd_en", w_t'(ram_cmd_en), w_t'(0));
    chk("abort_addr", w_t'(ram_addr), w_t'(0));
    chk("abort_cmd", w_t'(ram_cmd), w_t'(0));
    chk("abort_wr_data", w_t'(ram_wr_data), w_t'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_resp", w_t'(resp_cnt - r0), w_t'(0));
    last_line = '0;
    do_read(2, 1, 0, 1'b0, 0);

`ifndef BURST_LINE_CTRL_WRITE_EN
    // Write requests degrade to reads in the read-only build.
    do_read(1, 1, 0, 1'b1, 0);
`endif

    // Randomized traffic against the memory model.
    for (int n = 0; n < 12; n++) begin
      int line;
      line = $urandom_range(0, 3);
`ifdef BURST_LINE_CTRL_WRITE_EN
      if ($urandom_range(0, 1) == 1) do_write(line, rand_line());
      else do_read(line, 3, 0, 1'b0, $urandom_range(0, 2));
`else
      do_read(line, 3, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
